// File: rtl/sdc_pkg.sv
// Shared definitions for the SD-card SPI receive path: FSM states, token and
// error codes, and the CRC16-CCITT step used by the serial CRC engine.
package sdc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_R1,
    ST_R1,
    ST_WAIT_TOKEN,
    ST_DATA,
    ST_CRC,
    ST_DONE
  } state_e;

  typedef logic [2:0] err_t;

  localparam logic [7:0] TOKEN_START = 8'hFE;
  localparam logic [7:0] TOKEN_IDLE  = 8'hFF;

  localparam err_t ERR_OK            = 3'd0;
  localparam err_t ERR_R1_TIMEOUT    = 3'd1;
  localparam err_t ERR_R1_BAD        = 3'd2;
  localparam err_t ERR_TOKEN_TIMEOUT = 3'd3;
  localparam err_t ERR_DATA_TOKEN    = 3'd4;
  localparam err_t ERR_CRC           = 3'd5;

  localparam logic [15:0] CRC16_POLY = 16'h1021;

  // One MSB-first bit through CRC16-CCITT; feeding a frame plus its own CRC leaves 0.
  function automatic logic [15:0] crc16_step(input logic [15:0] rem, input logic din);
    logic fb;
    fb = rem[15] ^ din;
    return {rem[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sdc_resp_rx_if.sv
// Pin/handshake bundle between the SD response receiver and its user.
interface sdc_resp_rx_if;
  import sdc_pkg::*;

  logic       i_start;
  logic       i_data;
  logic       i_miso;
  logic       o_busy;
  logic       o_sck_en;
  logic [7:0] o_r1;
  logic       o_r1_valid;
  logic [7:0] o_byte;
  logic       o_byte_valid;
  logic       o_done;
  err_t       o_err;

  modport master (
    output i_start, i_data, i_miso,
    input  o_busy, o_sck_en, o_r1, o_r1_valid, o_byte, o_byte_valid, o_done, o_err
  );

  modport slave (
    input  i_start, i_data, i_miso,
    output o_busy, o_sck_en, o_r1, o_r1_valid, o_byte, o_byte_valid, o_done, o_err
  );

endinterface

// File: rtl/sdc_crc16.sv
// Serial CRC16-CCITT (poly 0x1021, init 0); shared by read and write paths.
module sdc_crc16
  import sdc_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic        i_bit,
  output logic [15:0] o_rem
);

  logic [15:0] rem_q, rem_d;

  always_comb begin
    rem_d = rem_q;
    if (i_clr)     rem_d = 16'h0000;
    else if (i_en) rem_d = crc16_step(rem_q, i_bit);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rem_q <= 16'h0000;
    else          rem_q <= rem_d;
  end

  assign o_rem = rem_q;

endmodule

// File: rtl/sdc_resp_rx.sv
// SPI-mode SD response receiver: finds R1, optionally waits for the start
// token, streams the data block out bytewise and checks its CRC16.
module sdc_resp_rx
  import sdc_pkg::*;
#(
  parameter int BLOCK_LEN = 512,
  parameter int NCR_MAX   = 8,
  parameter int TOKEN_MAX = 255
) (
  input logic          i_clk,
  input logic          i_rst_n,
  sdc_resp_rx_if.slave bus
);

  state_e      state_q, state_d;
  logic        data_q, data_d;
  logic [6:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [9:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  r1_q, r1_d;
  logic        r1_valid_q, r1_valid_d;
  logic [7:0]  byte_q, byte_d;
  logic        byte_valid_q, byte_valid_d;
  logic        done_q, done_d;
  err_t        err_q, err_d;
  logic        busy_q, busy_d;

  logic        crc_clr, crc_en;
  logic [15:0] crc_rem;
  logic [7:0]  byte_in;
  logic        last_bit;

  assign byte_in  = {shift_q, bus.i_miso};
  assign last_bit = (bit_cnt_q == 3'd7);

  sdc_crc16 u_crc (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (crc_clr),
    .i_en    (crc_en),
    .i_bit   (bus.i_miso),
    .o_rem   (crc_rem)
  );

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    r1_d         = r1_q;
    r1_valid_d   = 1'b0;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    done_d       = 1'b0;
    err_d        = err_q;
    busy_d       = busy_q;
    crc_clr      = 1'b0;
    crc_en       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // done_q still high means the previous transaction is in its o_done cycle
        if (bus.i_start && !done_q) begin
          state_d    = ST_WAIT_R1;
          data_d     = bus.i_data;
          err_d      = ERR_OK;
          r1_d       = 8'hFF;
          shift_d    = '0;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          crc_clr    = 1'b1;
          busy_d     = 1'b1;
        end
      end

      ST_WAIT_R1: begin
        shift_d = byte_in[6:0];
        if (!bus.i_miso) begin
          state_d   = ST_R1;
          bit_cnt_d = 3'd1;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (last_bit) begin
            byte_cnt_d = byte_cnt_q + 10'd1;
            if (byte_cnt_q == 10'(NCR_MAX - 1)) begin
              err_d   = ERR_R1_TIMEOUT;
              state_d = ST_DONE;
            end
          end
        end
      end

      ST_R1: begin
        shift_d   = byte_in[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (last_bit) begin
          r1_d       = byte_in;
          r1_valid_d = 1'b1;
          byte_cnt_d = '0;
          if (!data_q) begin
            state_d = ST_DONE;
          end else if (byte_in != 8'h00) begin
            err_d   = ERR_R1_BAD;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT_TOKEN;
          end
        end
      end

      ST_WAIT_TOKEN: begin
        shift_d   = byte_in[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (last_bit) begin
          if (byte_in == TOKEN_START) begin
            state_d    = ST_DATA;
            byte_cnt_d = '0;
          end else if (byte_in[7:4] == 4'h0) begin
            err_d   = ERR_DATA_TOKEN;
            state_d = ST_DONE;
          end else begin
            // anything else is treated like an idle 0xFF byte
            byte_cnt_d = byte_cnt_q + 10'd1;
            if (byte_cnt_q == 10'(TOKEN_MAX - 1)) begin
              err_d   = ERR_TOKEN_TIMEOUT;
              state_d = ST_DONE;
            end
          end
        end
      end

      ST_DATA: begin
        shift_d   = byte_in[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        crc_en    = 1'b1;
        if (last_bit) begin
          byte_d       = byte_in;
          byte_valid_d = 1'b1;
          if (byte_cnt_q == 10'(BLOCK_LEN - 1)) begin
            state_d    = ST_CRC;
            byte_cnt_d = '0;
          end else begin
            byte_cnt_d = byte_cnt_q + 10'd1;
          end
        end
      end

      ST_CRC: begin
        shift_d   = byte_in[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        crc_en    = 1'b1;
        if (last_bit) begin
          if (byte_cnt_q == 10'd1) state_d = ST_DONE;
          else                     byte_cnt_d = byte_cnt_q + 10'd1;
        end
      end

      ST_DONE: begin
        // CRC is only fed on the data path, so a non-zero residue can only come from there
        if (err_q == ERR_OK && crc_rem != 16'h0000) err_d = ERR_CRC;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      data_q       <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      r1_q         <= 8'hFF;
      r1_valid_q   <= 1'b0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= ERR_OK;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      r1_q         <= r1_d;
      r1_valid_q   <= r1_valid_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      done_q       <= done_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.o_busy       = busy_q;
  assign bus.o_sck_en     = busy_q;
  assign bus.o_r1         = r1_q;
  assign bus.o_r1_valid   = r1_valid_q;
  assign bus.o_byte       = byte_q;
  assign bus.o_byte_valid = byte_valid_q;
  assign bus.o_done       = done_q;
  assign bus.o_err        = err_q;

endmodule

// File: tb/tb_sdc_resp_rx.sv
// Directed + randomized bench for sdc_resp_rx against a byte-level reference model.
module tb_sdc_resp_rx;

  localparam int BLOCK_LEN = 512;
  localparam int NCR_MAX   = 8;
  localparam int TOKEN_MAX = 255;

  logic i_clk;
  logic i_rst_n;
  sdc_resp_rx_if bus ();

  sdc_resp_rx #(.BLOCK_LEN(BLOCK_LEN), .NCR_MAX(NCR_MAX), .TOKEN_MAX(TOKEN_MAX)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  bit         stim[$];
  logic [7:0] got_bytes[$];
  logic [7:0] exp_bytes[$];
  int   got_r1_n, got_r1_cyc, got_done_n, got_done_cyc;
  logic [2:0] got_err;
  int   exp_r1_n, exp_r1_cyc, exp_done_cyc;
  logic [7:0] exp_r1;
  logic [2:0] exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int j = 7; j >= 0; j--) stim.push_back(b[j]);
  endtask

  task automatic push_ones(input int n);
    for (int j = 0; j < n; j++) stim.push_back(1'b1);
  endtask

  // ---------------- reference model ----------------
  function automatic bit sb(input int i);
    return (i < stim.size()) ? stim[i] : 1'b1;
  endfunction

  function automatic logic [7:0] sbyte(input int p);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[7-j] = sb(p + j);
    return b;
  endfunction

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int j = 7; j >= 0; j--) begin
      if (r[15] ^ b[j]) r = (r << 1) ^ 16'h1021;
      else              r = r << 1;
    end
    return r;
  endfunction

  // Sample index i of the stream is seen by the DUT at edge (start edge + i + 1).
  function automatic void model(input bit data);
    int n, p, q;
    logic [7:0] b;
    logic [15:0] crc, rx;
    exp_bytes.delete();
    exp_r1 = 8'hFF; exp_r1_n = 0; exp_r1_cyc = -1; exp_err = 3'd0;
    n = -1;
    for (int i = 0; i < NCR_MAX * 8; i++) if (!sb(i)) begin n = i; break; end
    if (n < 0) begin exp_err = 3'd1; exp_done_cyc = NCR_MAX * 8 + 1; return; end
    exp_r1 = sbyte(n); exp_r1_n = 1; exp_r1_cyc = n + 8; exp_done_cyc = n + 9;
    if (!data) return;
    if (exp_r1 != 8'h00) begin exp_err = 3'd2; return; end
    p = n + 8; q = -1;
    for (int t = 0; t < TOKEN_MAX; t++) begin
      b = sbyte(p + 8 * t);
      if (b == 8'hFE) begin q = p + 8 * t + 8; break; end
      if (b[7:4] == 4'h0) begin exp_err = 3'd4; exp_done_cyc = p + 8 * t + 9; return; end
      if (t + 1 == TOKEN_MAX) begin exp_err = 3'd3; exp_done_cyc = p + 8 * t + 9; return; end
    end
    crc = 16'h0000;
    for (int i = 0; i < BLOCK_LEN; i++) begin
      b = sbyte(q + 8 * i);
      exp_bytes.push_back(b);
      crc = crc_byte(crc, b);
    end
    rx = {sbyte(q + 8 * BLOCK_LEN), sbyte(q + 8 * BLOCK_LEN + 8)};
    exp_err = (crc != rx) ? 3'd5 : 3'd0;
    exp_done_cyc = q + 8 * BLOCK_LEN + 17;
  endfunction

  // ---------------- driver / monitor ----------------
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},   bus.o_busy, 0);
    chk({tag, "_scken"},  bus.o_sck_en, 0);
    chk({tag, "_r1"},     bus.o_r1, 8'hFF);
    chk({tag, "_r1v"},    bus.o_r1_valid, 0);
    chk({tag, "_byte"},   bus.o_byte, 0);
    chk({tag, "_bytev"},  bus.o_byte_valid, 0);
    chk({tag, "_done"},   bus.o_done, 0);
    chk({tag, "_err"},    bus.o_err, 0);
  endtask

  task automatic run(input string tag, input bit data, input int poke_at,
                     input bit poke_on_done, input int rst_byte, input int max_cyc);
    int c, post, sidx;
    bit seen_done;
    got_bytes.delete();
    got_r1_n = 0; got_r1_cyc = -1; got_done_n = 0; got_done_cyc = -1; got_err = 3'd7;
    sidx = 0; post = 0; seen_done = 0;
    @(negedge i_clk);
    bus.i_start = 1'b1; bus.i_data = data;
    @(posedge i_clk); #1;
    bus.i_start = 1'b0;
    c = 0;
    while (1) begin
      bus.i_miso  = (sidx < stim.size()) ? stim[sidx] : 1'b1;
      sidx++;
      bus.i_start = (c == poke_at) || (poke_on_done && bus.o_done);
      @(posedge i_clk); #1;
      c++;
      if (c == 1) chk({tag, "_busy_rise"}, {bus.o_busy, bus.o_sck_en}, 2'b11);
      if (bus.o_r1_valid) begin got_r1_n++; got_r1_cyc = c; end
      if (bus.o_byte_valid) got_bytes.push_back(bus.o_byte);
      if (bus.o_done) begin
        got_done_n++; got_done_cyc = c; got_err = bus.o_err; seen_done = 1;
        chk({tag, "_busy_drop"}, bus.o_busy, 0);
      end
      if (rst_byte >= 0 && got_bytes.size() == rst_byte) begin
        i_rst_n = 1'b0;
        bus.i_start = 1'b0; bus.i_miso = 1'b1;
        #1;
        chk_reset_vals({tag, "_rst_now"});
        repeat (3) @(posedge i_clk);
        #1;
        chk_reset_vals({tag, "_rst_hold"});
        chk({tag, "_no_done"}, got_done_n, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        return;
      end
      if (seen_done) post++;
      if (post == 4 || c >= max_cyc) break;
    end
    bus.i_start = 1'b0;
    bus.i_miso  = 1'b1;
  endtask

  task automatic compare(input string tag);
    int mism, nb;
    chk({tag, "_done_n"},   got_done_n, 1);
    chk({tag, "_done_cyc"}, got_done_cyc, exp_done_cyc);
    chk({tag, "_err"},      got_err, exp_err);
    chk({tag, "_r1"},       bus.o_r1, exp_r1);
    chk({tag, "_r1_n"},     got_r1_n, exp_r1_n);
    if (exp_r1_n != 0) chk({tag, "_r1_cyc"}, got_r1_cyc, exp_r1_cyc);
    chk({tag, "_nbytes"},   got_bytes.size(), exp_bytes.size());
    mism = 0;
    nb = (got_bytes.size() < exp_bytes.size()) ? got_bytes.size() : exp_bytes.size();
    for (int i = 0; i < nb; i++) if (got_bytes[i] !== exp_bytes[i]) mism++;
    chk({tag, "_bytes"},    mism, 0);
    chk({tag, "_idle_busy"}, bus.o_busy, 0);
  endtask

  task automatic build_block(input logic [15:0] crc, input logic [7:0] token);
    stim.delete();
    push_byte(8'h00);
    repeat (3) push_byte(8'hFF);
    push_byte(token);
    repeat (BLOCK_LEN) push_byte(8'hFF);
    push_byte(crc[15:8]); push_byte(crc[7:0]);
  endtask

  task automatic do_txn(input string tag, input bit data, input int poke_at, input bit poke_on_done);
    model(data);
    run(tag, data, poke_at, poke_on_done, -1, exp_done_cyc + 20);
    compare(tag);
  endtask

  initial begin
    logic [15:0] crc;
    logic [7:0]  b;
    int          nlead, nwait;
    i_rst_n = 1'b0;
    bus.i_start = 1'b0; bus.i_data = 1'b0; bus.i_miso = 1'b1;
    repeat (3) @(negedge i_clk);
    chk_reset_vals("reset");
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk_reset_vals("post_reset");

    // R1 0x01 after two idle bytes; extra start during o_done must be ignored
    stim.delete();
    push_byte(8'hFF); push_byte(8'hFF); push_byte(8'h01);
    do_txn("r1_01", 1'b0, -1, 1'b1);
    chk("r1_01_cyc24", got_r1_cyc, 24);

    // no response at all
    stim.delete();
    do_txn("r1_timeout", 1'b0, -1, 1'b0);
    chk("r1_timeout_err", got_err, 3'd1);

    build_block(16'h7FA1, 8'hFE);
    do_txn("blk_ok", 1'b1, -1, 1'b0);
    chk("blk_ok_err", got_err, 3'd0);

    build_block(16'h7FA0, 8'hFE);
    do_txn("blk_badcrc", 1'b1, -1, 1'b0);
    chk("blk_badcrc_err", got_err, 3'd5);

    build_block(16'h7FA1, 8'h05);
    do_txn("blk_errtok", 1'b1, -1, 1'b0);
    chk("blk_errtok_nbytes", got_bytes.size(), 0);

    // bad R1 with data requested, plus a start pulse while busy
    stim.delete();
    push_ones(5); push_byte(8'h04);
    do_txn("r1_bad", 1'b1, 3, 1'b0);
    chk("r1_bad_err", got_err, 3'd2);

    // token never arrives
    stim.delete();
    push_byte(8'h00);
    repeat (TOKEN_MAX + 2) push_byte(8'hFF);
    do_txn("tok_timeout", 1'b1, -1, 1'b0);

    // random no-data responses at arbitrary bit offsets
    for (int k = 0; k < 4; k++) begin
      stim.delete();
      push_ones($urandom_range(0, 55));
      push_byte(8'($urandom_range(0, 127)));
      do_txn($sformatf("rnd_r1_%0d", k), 1'b0, -1, 1'b0);
    end

    // random data blocks, random token wait, occasionally corrupted CRC
    for (int k = 0; k < 3; k++) begin
      stim.delete();
      nlead = $urandom_range(0, 30);
      push_ones(nlead);
      push_byte(8'h00);
      nwait = $urandom_range(0, 5);
      for (int t = 0; t < nwait; t++) begin
        b = 8'($urandom_range(16, 255));
        if (b == 8'hFE) b = 8'hFF;
        push_byte(b);
      end
      push_byte(8'hFE);
      crc = 16'h0000;
      for (int i = 0; i < BLOCK_LEN; i++) begin
        b = 8'($urandom);
        push_byte(b);
        crc = crc_byte(crc, b);
      end
      if (k == 1) crc = crc ^ 16'(1 << $urandom_range(0, 15));
      push_byte(crc[15:8]); push_byte(crc[7:0]);
      do_txn($sformatf("rnd_blk_%0d", k), 1'b1, -1, 1'b0);
    end

    // reset during data byte 100, then a clean transaction
    build_block(16'h7FA1, 8'hFE);
    run("midrst", 1'b1, -1, 1'b0, 100, 6000);
    build_block(16'h7FA1, 8'hFE);
    do_txn("after_rst", 1'b1, -1, 1'b0);
    chk("after_rst_err", got_err, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdc_resp_rx.md
# sdc_resp_rx

SPI-mode SD card response receiver: the MISO-side counterpart of the command sender. After a command frame has been shifted out, it samples MISO, finds and captures the R1 response, and, for read commands, waits for the start-block token. It then streams the data block out byte-by-byte and checks the trailing CRC16. It sits between the SPI pins and the sector-buffer logic, sharing the SCK that the command sender drives on the falling edge.

## Interface
- BLOCK_LEN, 512: data bytes per block.
- NCR_MAX, 8: max bytes (×8 bits) to wait for the R1 start bit.
- TOKEN_MAX, 255: max bytes to wait for the start-block token.
- i_clk  in  1  SCK-rate clock; MISO sampled on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle pulse; begin response reception (ignored while o_busy).
- i_data  in  1  sampled with i_start; 1 = a data block follows R1.
- i_miso  in  1  SD card DO line.
- o_busy  out  1  high from the cycle after accepted i_start until o_done.
- o_sck_en  out  1  request for SCK toggling; equals o_busy.
- o_r1  out  8  captured R1; holds until the next accepted i_start.
- o_r1_valid  out  1  one-cycle pulse when o_r1 updates.
- o_byte  out  8  received data byte.
- o_byte_valid  out  1  one-cycle pulse per data byte.
- o_done  out  1  one-cycle pulse at end of transaction.
- o_err  out  3  0 ok, 1 R1 timeout, 2 R1≠0 with i_data, 3 token timeout, 4 data error token, 5 CRC mismatch; valid with o_done, held until the next accepted i_start.

## Operation
- States: IDLE → WAIT_R1 → R1 → (WAIT_TOKEN → DATA → CRC) → DONE → IDLE.
- IDLE: on i_start, latch i_data, clear o_err and the counters, go to WAIT_R1.
- WAIT_R1: sample one bit per cycle. The first 0 is R1 bit 7; go to R1. If NCR_MAX×8 consecutive 1s are sampled, set err=1 and go to DONE.
- R1: shift in the remaining 7 bits MSB-first. Then pulse o_r1_valid with o_r1 updated.
  - No data latched: go to DONE.
  - Data latched and R1≠0x00: err=2, go to DONE.
  - Otherwise: go to WAIT_TOKEN.
- WAIT_TOKEN: byte-aligned to the end of R1. Per byte:
  - 0xFE: go to DATA.
  - 0xFF: keep waiting, and count the byte.
  - Upper nibble 0000 (error token): err=4, go to DONE.
  - Any other value: treat as 0xFF.
  - After TOKEN_MAX counted bytes: err=3, go to DONE.
- DATA: receive BLOCK_LEN bytes MSB-first and pulse o_byte_valid for each. Feed each bit into CRC16-CCITT (poly 0x1021, init 0x0000).
- CRC: feed the 16 received CRC bits into the same CRC register. A non-zero remainder sets err=5.
- DONE: pulse o_done, go to IDLE.
- Byte counter: 10 bits, wide enough for BLOCK_LEN-1. Bit counter: 3 bits, wraps at 8.
- Reset, including mid-transaction: state IDLE, all outputs 0, o_r1=0xFF, counters and CRC cleared. No partial o_done is issued.

## Timing
- i_start sampled at rising edge k; first MISO sample at edge k+1; o_busy/o_sck_en high from k+1.
- R1 with start bit at sample n (0-based): o_r1_valid asserted in the cycle after sample n+7.
- o_byte_valid is asserted in the cycle after a byte's 8th bit; there is at most one pulse per 8 cycles.
- No-data transaction: o_done is one cycle after o_r1_valid.
- Data transaction: o_done is one cycle after the 16th CRC bit. o_busy drops in the same cycle as o_done.
- i_start during o_busy or o_done is ignored.
- The block has no backpressure; the consumer must accept every o_byte_valid.

## Structure
- Shared package sdc_pkg holds:
  - state enum;
  - token constants 0xFE and 0xFF;
  - error code constants;
  - CRC16 polynomial 0x1021.
- Sub-module sdc_crc16: a serial CRC16-CCITT with clear, enable and bit inputs and a 16-bit remainder output. It is reusable by the future write path.

## Test plan
- MISO 0xFF×2 then 0x01, i_data=0 → o_r1=0x01, o_r1_valid at cycle 24 after start, o_done next cycle, o_err=0.
- MISO all 1s, i_data=0 → o_done after 64 samples, o_err=1, o_r1=0xFF.
- i_data=1:
  - Stimulus: R1 0x00, then 0xFF×3, 0xFE, 512×0xFF, CRC 0x7FA1.
  - Response: 512 o_byte_valid pulses of 0xFF, o_err=0.
- Same as the previous test but CRC 0x7FA0 → o_err=5. Same but token 0x05 instead of 0xFE → o_err=4, no o_byte_valid.
- R1 0x04 with i_data=1 → o_err=2. Second i_start during o_busy → ignored, exactly one o_done.
- i_rst_n low at data byte 100 → outputs return to reset values immediately, no o_done; a fresh transaction afterwards completes with o_err=0.
